// File: rtl/scs_gen.sv
// System control/status block: masked error capture, multi-cycle reset pulse FSM and an error log that survives sys_rst.
// Optional feature macro SCS_ERR_CNT_EN adds a saturating hardware-error capture counter in MASK[31:16].
module scs_gen #(
    parameter int NUM_ERR    = 8,
    parameter int PID_W      = 5,
    parameter int EA_W       = 24,
    parameter int RST_CYCLES = 4,
    parameter int LOG_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stb,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [NUM_ERR-1:0] err_sig,
    input  logic [EA_W-1:0]    err_addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               sys_rst,
    output logic               sys_rst_n,
    output logic [PID_W-1:0]   cp_pid,
    output logic               ack
);
    localparam int PW  = $clog2(LOG_DEPTH);
    localparam int CW  = PW + 1;
    localparam int RCW = $clog2(RST_CYCLES) + 1;
    localparam int LW  = EA_W + 8;

    typedef enum logic [1:0] {IDLE, ARM, PULSE} state_t;
    state_t state, state_nx;

    logic [4:0]         scs_hi;
    logic [1:0]         scs_lo;
    logic [PID_W-1:0]   err_pid;
    logic [7:0]         err_no;
    logic [EA_W-1:0]    err_addr_r;
    logic [NUM_ERR-1:0] mask;
    logic               ovf;
    logic [RCW-1:0]     rcnt;

    logic [LW-1:0]      log_mem [LOG_DEPTH];
    logic [PW-1:0]      head, tail;
    logic [CW-1:0]      log_count;

    logic [NUM_ERR-1:0] err_act;
    logic               err_hit;
    logic [3:0]         err_idx;
    logic               rd, capture, bus_wr, scs_wr, err_wr, mask_wr;
    logic               push, pop, log_full, log_empty;
    logic [LW-1:0]      push_data;
    logic [31:0]        rd_data;

`ifdef SCS_ERR_CNT_EN
    logic [15:0]        err_cnt;
`endif

    assign err_act   = err_sig & mask;
    assign err_hit   = |err_act;
    assign rd        = stb && !we;
    assign capture   = (state == IDLE) && err_hit;
    // A hardware capture wins the cycle; a coincident bus write is dropped.
    assign bus_wr    = (state == IDLE) && !err_hit && stb && we;
    assign scs_wr    = bus_wr && (addr == 2'd0);
    assign err_wr    = bus_wr && (addr == 2'd1);
    assign mask_wr   = bus_wr && (addr == 2'd2);
    assign log_empty = (log_count == '0);
    assign log_full  = (log_count == CW'(LOG_DEPTH));
    assign pop       = rd && (addr == 2'd3) && !log_empty;
    assign push      = capture || (err_wr && (data_in[7:0] != 8'h00));
    assign push_data = capture ? {err_addr, 4'h8, err_idx} : {data_in[8 +: EA_W], data_in[7:0]};
    assign ack       = stb;
    assign sys_rst_n = ~sys_rst;

    always_comb begin
        err_idx = '0;
        for (int unsigned i = 0; i < NUM_ERR; i++) begin
            if (err_act[NUM_ERR-1-i]) err_idx = 4'(NUM_ERR-1-i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sys_rst  = rst;
        case (state)
            IDLE:  if (capture || (scs_wr && data_in[1])) state_nx = ARM;
            ARM:   state_nx = PULSE;
            PULSE: begin
                sys_rst = 1'b1;
                if (rcnt == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scs_hi     <= '0;
            scs_lo     <= '0;
            cp_pid     <= '0;
            err_pid    <= '0;
            err_no     <= '0;
            err_addr_r <= '0;
            mask       <= '1;
            ovf        <= 1'b0;
            rcnt       <= '0;
        end else begin
            if (state == ARM) begin
                scs_hi <= '0;
                scs_lo <= '0;
                cp_pid <= '0;
                rcnt   <= RCW'(RST_CYCLES - 1);
            end else if (state == PULSE && rcnt != '0) begin
                rcnt <= rcnt - RCW'(1);
            end
            if (capture) begin
                err_no     <= {4'h8, err_idx};
                err_addr_r <= err_addr;
                err_pid    <= cp_pid;
            end
            if (scs_wr) begin
                scs_hi  <= data_in[7:3];
                scs_lo  <= data_in[1:0];
                cp_pid  <= data_in[8 +: PID_W];
                err_pid <= data_in[8+PID_W +: PID_W];
            end
            if (err_wr) begin
                err_no     <= data_in[7:0];
                err_addr_r <= data_in[8 +: EA_W];
            end
            if (mask_wr) mask <= data_in[NUM_ERR-1:0];
            if (scs_wr && data_in[2]) ovf <= 1'b0;
            if (push && log_full && !pop) ovf <= 1'b1;
        end
    end

`ifdef SCS_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              err_cnt <= '0;
        else if (capture && err_cnt != '1)    err_cnt <= err_cnt + 16'd1;
    end
`endif

    // When full, a push without a pop overwrites the oldest slot (tail == head) and drags head along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            log_count <= '0;
            for (int unsigned i = 0; i < LOG_DEPTH; i++) log_mem[i] <= '0;
        end else begin
            if (push) begin
                log_mem[tail] <= push_data;
                tail          <= tail + PW'(1);
            end
            if (pop || (push && log_full)) head <= head + PW'(1);
            if (push && !pop && !log_full) log_count <= log_count + CW'(1);
            else if (pop && !push)         log_count <= log_count - CW'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0: begin
                rd_data[7:0]                 = {scs_hi, ovf, scs_lo};
                rd_data[8 +: PID_W]          = cp_pid;
                rd_data[8+PID_W +: PID_W]    = err_pid;
                rd_data[31:28]               = 4'(log_count);
            end
            2'd1: begin
                rd_data[8 +: EA_W]           = err_addr_r;
                rd_data[7:0]                 = err_no;
            end
            2'd2: begin
                rd_data[NUM_ERR-1:0]         = mask;
`ifdef SCS_ERR_CNT_EN
                rd_data[31:16]               = err_cnt;
`endif
            end
            default: begin
                if (!log_empty) rd_data[LW-1:0] = log_mem[head];
            end
        endcase
        data_out = rd ? rd_data : '0;
    end

endmodule

// File: tb/tb_scs_gen.sv
// Randomised plus directed bench for scs_gen against a queue-based behavioural model.
module tb_scs_gen;
    localparam int NUM_ERR    = 8;
    localparam int PID_W      = 5;
    localparam int EA_W       = 24;
    localparam int RST_CYCLES = 4;
    localparam int LOG_DEPTH  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stb = 1'b0;
    logic               we = 1'b0;
    logic [1:0]         addr = '0;
    logic [NUM_ERR-1:0] err_sig = '0;
    logic [EA_W-1:0]    err_addr = '0;
    logic [31:0]        data_in = '0;
    logic [31:0]        data_out;
    logic               sys_rst, sys_rst_n, ack;
    logic [PID_W-1:0]   cp_pid;

    scs_gen #(
        .NUM_ERR(NUM_ERR), .PID_W(PID_W), .EA_W(EA_W),
        .RST_CYCLES(RST_CYCLES), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .err_sig(err_sig), .err_addr(err_addr), .data_in(data_in),
        .data_out(data_out), .sys_rst(sys_rst), .sys_rst_n(sys_rst_n),
        .cp_pid(cp_pid), .ack(ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Behavioural model: register values, log as a queue, busy = cycles left until the block is idle again.
    logic [7:0]         m_scs;
    int unsigned        m_cp, m_ep, m_cnt;
    logic [7:0]         m_eno;
    logic [31:0]        m_ea;
    logic [NUM_ERR-1:0] m_mask;
    logic               m_ovf;
    int                 m_busy;
    logic [31:0]        logq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_scs = '0; m_cp = 0; m_ep = 0; m_cnt = 0; m_eno = '0; m_ea = '0;
        m_mask = '1; m_ovf = 1'b0; m_busy = 0;
        logq.delete();
    endtask

    task automatic log_push(input logic [31:0] v);
        logic [31:0] junk;
        if (logq.size() == LOG_DEPTH) begin
            junk = logq.pop_front();
            m_ovf = 1'b1;
        end
        logq.push_back(v);
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        case (a)
            2'd0: r = (32'(logq.size()) << 28) | (32'(m_ep) << (8 + PID_W)) | (32'(m_cp) << 8)
                      | 32'(m_scs & 8'hFB) | (m_ovf ? 32'h4 : 32'h0);
            2'd1: r = (m_ea << 8) | 32'(m_eno);
`ifdef SCS_ERR_CNT_EN
            2'd2: r = (32'(m_cnt) << 16) | 32'(m_mask);
`else
            2'd2: r = 32'(m_mask);
`endif
            default: r = (logq.size() != 0) ? logq[0] : 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_edge(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                              input logic [NUM_ERR-1:0] e, input logic [EA_W-1:0] ea);
        logic [31:0] junk;
        logic [NUM_ERR-1:0] act;
        int first;
        if (s && !w && a == 2'd3 && logq.size() != 0) junk = logq.pop_front();
        if (m_busy == 0) begin
            act = e & m_mask;
            if (act != '0) begin
                first = -1;
                for (int i = 0; i < NUM_ERR; i++) if (act[i] && first < 0) first = i;
                m_eno = 8'(128 + first);
                m_ea = 32'(ea);
                m_ep = m_cp;
                log_push((m_ea << 8) | 32'(m_eno));
                m_busy = RST_CYCLES + 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (s && w) begin
                case (a)
                    2'd0: begin
                        m_scs = d[7:0];
                        m_cp = (d >> 8) & ((32'h1 << PID_W) - 1);
                        m_ep = (d >> (8 + PID_W)) & ((32'h1 << PID_W) - 1);
                        if (d[2]) m_ovf = 1'b0;
                        if (d[1]) m_busy = RST_CYCLES + 1;
                    end
                    2'd1: begin
                        m_eno = d[7:0];
                        m_ea = (d >> 8) & ((32'h1 << EA_W) - 1);
                        if (d[7:0] != 8'h00) log_push((m_ea << 8) | 32'(m_eno));
                    end
                    2'd2: m_mask = d[NUM_ERR-1:0];
                    default: ;
                endcase
            end
        end else begin
            if (m_busy == RST_CYCLES + 1) begin
                m_scs = '0;
                m_cp = 0;
            end
            m_busy--;
        end
    endtask

    task automatic step(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [NUM_ERR-1:0] e, input logic [EA_W-1:0] ea,
                        output logic [31:0] rdv, output logic srv);
        logic exp_sr;
        @(negedge clk);
        stb = s; we = w; addr = a; data_in = d; err_sig = e; err_addr = ea;
        #1;
        exp_sr = (m_busy >= 1) && (m_busy <= RST_CYCLES);
        check("data_out", data_out, (s && !w) ? model_read(a) : 32'h0);
        check("sys_rst", 32'(sys_rst), 32'(exp_sr));
        check("sys_rst_n", 32'(sys_rst_n), 32'(!exp_sr));
        check("cp_pid", 32'(cp_pid), 32'(m_cp));
        check("ack", 32'(ack), 32'(s));
        rdv = data_out;
        srv = sys_rst;
        @(posedge clk);
        model_edge(s, w, a, d, e, ea);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        logic sr;
        step(1'b1, 1'b0, a, $urandom, '0, EA_W'($urandom), v, sr);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] v;
        logic sr;
        step(1'b1, 1'b1, a, d, '0, EA_W'($urandom), v, sr);
    endtask

    task automatic hit(input logic [NUM_ERR-1:0] e, input logic [EA_W-1:0] ea);
        logic [31:0] v;
        logic sr;
        step(1'b0, 1'b0, 2'd0, 32'h0, e, ea, v, sr);
    endtask

    task automatic idle(input int n, output int hi, output logic first_sr);
        logic [31:0] v;
        logic sr;
        hi = 0;
        first_sr = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 2'd0, 32'h0, '0, EA_W'($urandom), v, sr);
            if (i == 0) first_sr = sr;
            if (sr) hi++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stb = 1'b0; we = 1'b0; err_sig = '0;
        #1;
        check("rst_sys_rst", 32'(sys_rst), 32'h1);
        check("rst_sys_rst_n", 32'(sys_rst_n), 32'h0);
        check("rst_cp_pid", 32'(cp_pid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, d;
        logic sr, s, w;
        logic [1:0] a;
        logic [NUM_ERR-1:0] e;
        int hi;

        model_reset();
        do_reset();
        rd(2'd0, v); check("reset_scs", v, 32'h0);
        rd(2'd2, v); check("reset_mask", v, 32'h0000_00FF);
        rd(2'd3, v); check("reset_log", v, 32'h0);

        wr(2'd0, 32'h0000_0302);
        idle(8, hi, sr);
        check("arm_low", 32'(sr), 32'h0);
        check("sw_pulse_len", 32'(hi), 32'd4);
        rd(2'd0, v); check("scs_after_pulse", v, 32'h0);

        wr(2'd0, 32'h0000_0500);
        hit(8'b0010_0100, 24'h00ABCD);
        idle(6, hi, sr);
        check("err_pulse_len", 32'(hi), 32'd4);
        rd(2'd1, v); check("err_capture", v, 32'h00AB_CD82);
        rd(2'd0, v); check("err_pid", (v >> 13) & 32'h1F, 32'd5);
        check("log_count1", v >> 28, 32'd1);
        rd(2'd3, v); check("log_pop", v, 32'h00AB_CD82);
        rd(2'd0, v); check("log_count0", v >> 28, 32'd0);

        wr(2'd2, 32'h0000_00FB);
        hit(8'h04, 24'h000111);
        idle(4, hi, sr);
        check("masked_no_pulse", 32'(hi), 32'd0);
        hit(8'h0C, 24'h000222);
        idle(6, hi, sr);
        rd(2'd1, v); check("mask_priority", v & 32'hFF, 32'h83);
        wr(2'd2, 32'h0000_00FF);

        for (int i = 0; i < LOG_DEPTH + 1; i++) rd(2'd3, v);
        for (int i = 1; i <= 5; i++) wr(2'd1, (32'(i) << 8) | 32'(i));
        rd(2'd0, v);
        check("ovf_set", (v >> 2) & 32'h1, 32'h1);
        check("count_full", v >> 28, 32'd4);
        for (int i = 2; i <= 5; i++) begin
            rd(2'd3, v); check("ovf_pop", v, (32'(i) << 8) | 32'(i));
        end
        rd(2'd3, v); check("pop_empty", v, 32'h0);
        wr(2'd0, 32'h0000_0004);
        rd(2'd0, v); check("ovf_w1c", (v >> 2) & 32'h1, 32'h0);

        do_reset();
        hit(8'h01, 24'h000010); idle(6, hi, sr);
        hit(8'h02, 24'h000020); idle(6, hi, sr);
        hit(8'h40, 24'h000030); idle(6, hi, sr);
        rd(2'd2, v);
`ifdef SCS_ERR_CNT_EN
        check("err_cnt3", v >> 16, 32'd3);
`else
        check("err_cnt_absent", v >> 16, 32'd0);
`endif
        step(1'b1, 1'b1, 2'd0, 32'h0000_0711, 8'h80, 24'h001234, v, sr);
        rd(2'd0, v); check("wr_dropped", v & 32'h1FFF, 32'h0);
        idle(6, hi, sr);
        rd(2'd1, v); check("simul_capture", v, 32'h0012_3487);

        wr(2'd1, 32'h0000_5509);
        wr(2'd0, 32'h0000_0102);
        idle(2, hi, sr);
        check("mid_pulse", 32'(hi), 32'd1);
        do_reset();
        rd(2'd0, v); check("rst_scs", v, 32'h0);
        rd(2'd1, v); check("rst_err", v, 32'h0);
        rd(2'd2, v); check("rst_mask", v, 32'h0000_00FF);
        rd(2'd3, v); check("rst_log", v, 32'h0);

        for (int k = 0; k < 600; k++) begin
            s = ($urandom % 4) != 0;
            w = 1'($urandom % 2);
            a = 2'($urandom % 4);
            d = $urandom;
            if (($urandom % 4) != 0) d[1] = 1'b0;
            e = (($urandom % 6) == 0) ? NUM_ERR'($urandom) : '0;
            step(s, w, a, d, e, EA_W'($urandom), v, sr);
        end
        idle(8, hi, sr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
